// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; one quotient bit per cycle.
// Signed operands are divided by magnitude, then the quotient and remainder signs are fixed up.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_e;

  state_e      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;
  logic [31:0] abs1;
  logic [31:0] abs2;

  always_comb begin
    // {rem, quo[31]} is the shifted partial remainder; it can need 33 bits.
    diff    = {rem, quo[31]} - {1'b0, dsr};
    rem_nxt = diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
    quo_nxt = {quo[30:0], ~diff[32]};
    rem_fix = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    quo_fix = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    abs1    = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs2    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dsr      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      // Flush wins over any start; nothing is produced for the cancelled op.
      state    <= DivFree;
      cnt      <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
          if (start_i) begin
            rem   <= 32'd0;
            quo   <= abs1;
            dsr   <= abs2;
            neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_div_i & opdata1_i[31];
            cnt   <= 6'd0;
            state <= (opdata2_i == 32'd0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= 64'd0;
          ready_o  <= 1'b1;
        end
        DivOn: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state    <= DivEnd;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end
        end
        DivEnd: begin
          if (!start_i) begin
            state    <= DivFree;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Bench for div: table of divide vectors through a result scoreboard, plus annul/reset sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int chk = 0;
  int err = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          dbz;
  } vec_t;

  vec_t vecs[12];

  div u_div (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for ready; operands are scrambled after the capture edge to prove they are ignored.
  task automatic wait_ready(input bit scramble, output int edges);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && !ready) begin
        op1 = $urandom;
        op2 = $urandom;
      end
    end while (!ready && n < 40);
    edges = n;
  endtask

  task automatic finish_op(input string name, input int edges, input bit dbz);
    logic [63:0] want;
    logic [63:0] held;
    want = sb.pop_front();
    if (!ready) begin
      check({name, "_timeout"}, 64'(ready), 64'd1);
      start = 1'b0;
      @(negedge clk);
      return;
    end
    check({name, "_result"}, result, want);
    // edges counts negedges after the capture edge E0, so ready after Ek gives k+1.
    if (dbz) check({name, "_dbz_latency_le2"}, 64'(edges <= 3), 64'd1);
    else     check({name, "_latency"}, 64'(edges - 1), 64'd32);
    held = result;
    @(negedge clk);
    check({name, "_hold_ready"}, 64'(ready), 64'd1);
    check({name, "_hold_result"}, result, held);
    start = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, 64'(ready), 64'd0);
    check({name, "_drop_result"}, result, 64'd0);
  endtask

  task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit dbz);
    int edges;
    @(negedge clk);
    signed_div = sg;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    sb.push_back(exp);
    wait_ready(1'b1, edges);
    finish_op(name, edges, dbz);
  endtask

  task automatic expect_silent(input string name, input int cycles);
    bit rose = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready) rose = 1'b1;
    end
    check(name, 64'(rose), 64'd0);
  endtask

  initial begin
    int edges;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 1'b0};
    vecs[3]  = '{1'b0, 32'h00001234,   32'd0,          64'h0,                 1'b1};
    vecs[4]  = '{1'b1, 32'h00001234,   32'd0,          64'h0,                 1'b1};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 1'b0};
    vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 1'b0};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 1'b0};
    vecs[10] = '{1'b1, 32'd5,          32'd7,          64'h00000005_00000000, 1'b0};
    vecs[11] = '{1'b0, 32'd1000,       32'd10,         64'h00000000_00000064, 1'b0};

    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dbz);

    // Annul ten cycles into the iteration: no result, then a fresh op completes normally.
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'h12345678;
    op2        = 32'd3;
    start      = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    annul = 1'b0;
    expect_silent("annul_no_ready", 40);
    run_op("after_annul", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 1'b0);

    // Annul coincident with start in DivFree must block acceptance.
    @(negedge clk);
    op1   = 32'd9;
    op2   = 32'd3;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    expect_silent("annul_blocks_start", 40);

    // Reset mid-divide with start held; the held start restarts after release.
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'd500;
    op2        = 32'd7;
    start      = 1'b1;
    sb.push_back(64'h00000003_00000047);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_result", result, 64'd0);
    rst = 1'b0;
    wait_ready(1'b1, edges);
    finish_op("after_reset", edges, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
